// File: rtl/spi_flash_pkg.sv
// Shared types for the spi_flash_read request scheduler: FSM states, read-mode
// codes, geometry defaults and the segment record produced by the splitter.
package spi_flash_pkg;

  localparam int DIE_SIZE_LOG2_DEF = 25;
  localparam int SEG_MAX_LOG2_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10
  } mode_e;

  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic        switch_die;
  } seg_t;

  // The reserved code 11 falls back to single-line reads.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    r = (m == 2'b11) ? MODE_SINGLE : m;
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_read_sched_if.sv
// Job request handshake plus the per-segment command bus towards spi_flash_read.
// valid/ready: a job transfers on a rising clock edge where req_valid && req_ready;
// the requester may change or drop req_* freely when no transfer happens.
interface spi_flash_read_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_len;
  logic [1:0]  req_mode;
  logic [31:0] start_addr;
  logic [31:0] end_addr;
  logic [1:0]  mode;
  logic        switch_die_need;
  logic        start_flag;
  logic        read_finish;
  logic        busy;
  logic        done;
  logic        err;
  logic        timeout;

  modport master (
    output req_valid, req_addr, req_len, req_mode, read_finish,
    input  req_ready, start_addr, end_addr, mode, switch_die_need,
    input  start_flag, busy, done, err, timeout
  );

  modport slave (
    input  req_valid, req_addr, req_len, req_mode, read_finish,
    output req_ready, start_addr, end_addr, mode, switch_die_need,
    output start_flag, busy, done, err, timeout
  );
endinterface

// File: rtl/spi_flash_seg_calc.sv
// Combinational segment splitter: clips the remaining range at the next aligned
// segment boundary and the next die boundary, and flags a die change.
module spi_flash_seg_calc
  import spi_flash_pkg::*;
#(
  parameter int DIE_SIZE_LOG2 = DIE_SIZE_LOG2_DEF,
  parameter int SEG_MAX_LOG2  = SEG_MAX_LOG2_DEF
) (
  input  logic [31:0]              cur_addr,
  input  logic [31:0]              last,
  input  logic [31-DIE_SIZE_LOG2:0] cur_die,
  output seg_t                     seg
);

  localparam logic [31:0] SEG_MASK = 32'((64'd1 << SEG_MAX_LOG2) - 64'd1);
  localparam logic [31:0] DIE_MASK = 32'((64'd1 << DIE_SIZE_LOG2) - 64'd1);

  logic [31:0] seg_lim;
  logic [31:0] die_lim;
  logic [31:0] bound;

  always_comb begin
    seg_lim        = cur_addr | SEG_MASK;
    die_lim        = cur_addr | DIE_MASK;
    bound          = (seg_lim < die_lim) ? seg_lim : die_lim;
    seg.start_addr = cur_addr;
    seg.end_addr   = (last < bound) ? last : bound;
    seg.switch_die = (cur_addr[31:DIE_SIZE_LOG2] != cur_die);
  end

endmodule

// File: rtl/spi_flash_read_sched.sv
// Splits one byte-range read job into die/segment-bounded segments and launches
// them one at a time into spi_flash_read. Optional WAIT watchdog: SPI_FLASH_SCHED_TIMEOUT_EN.
module spi_flash_read_sched
  import spi_flash_pkg::*;
#(
  parameter int DIE_SIZE_LOG2 = DIE_SIZE_LOG2_DEF,
  parameter int SEG_MAX_LOG2  = SEG_MAX_LOG2_DEF
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                  system_clk,
  input  logic                  system_reset_n,
  spi_flash_read_sched_if.slave bus,
  output state_e                state_dbg
);

  localparam int DIE_W = 32 - DIE_SIZE_LOG2;

  state_e            state_q;
  state_e            state_d;
  logic [31:0]       cur_addr_q;
  logic [31:0]       last_q;
  logic [1:0]        mode_q;
  logic [DIE_W-1:0]  cur_die_q;
  logic [31:0]       start_addr_q;
  logic [31:0]       end_addr_q;
  logic [1:0]        mode_out_q;
  logic              switch_die_q;
  logic              req_ready_q;
  logic              start_flag_q;
  logic              done_q;
  logic              err_q;
  logic              hs;
  logic              bad_job;
  logic              job_done;
  logic              seg_next;
  logic [32:0]       last_sum;
  seg_t              seg;
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
  logic [31:0]       wait_cnt_q;
  logic              job_timeout;
  logic              timeout_q;
`endif

  // Bit 32 of the inclusive last address flags a range running past 0xFFFFFFFF.
  assign last_sum = {1'b0, bus.req_addr} + {1'b0, bus.req_len} - 33'd1;
  assign bad_job  = (bus.req_len == 32'd0) || last_sum[32];
  assign hs       = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;

  spi_flash_seg_calc #(
    .DIE_SIZE_LOG2 (DIE_SIZE_LOG2),
    .SEG_MAX_LOG2  (SEG_MAX_LOG2)
  ) u_seg_calc (
    .cur_addr (cur_addr_q),
    .last     (last_q),
    .cur_die  (cur_die_q),
    .seg      (seg)
  );

  always_comb begin
    state_d  = state_q;
    job_done = 1'b0;
    seg_next = 1'b0;
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
    job_timeout = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (hs && !bad_job) state_d = ST_CALC;
      end
      ST_CALC:  state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.read_finish) begin
          if (end_addr_q == last_q) begin
            job_done = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            seg_next = 1'b1;
            state_d  = ST_CALC;
          end
        end
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          job_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      last_q       <= '0;
      mode_q       <= '0;
      cur_die_q    <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      mode_out_q   <= '0;
      switch_die_q <= 1'b0;
      req_ready_q  <= 1'b0;
      start_flag_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == ST_IDLE);
      start_flag_q <= (state_d == ST_ISSUE);
      done_q       <= job_done;
      err_q        <= hs && bad_job;
      if (hs) begin
        cur_addr_q <= bus.req_addr;
        last_q     <= last_sum[31:0];
        mode_q     <= norm_mode(bus.req_mode);
      end
      // Segment outputs change only here, so they hold through ISSUE, WAIT and IDLE.
      if (state_q == ST_CALC) begin
        start_addr_q <= seg.start_addr;
        end_addr_q   <= seg.end_addr;
        switch_die_q <= seg.switch_die;
        mode_out_q   <= mode_q;
      end
      if (state_q == ST_ISSUE) cur_die_q <= start_addr_q[31:DIE_SIZE_LOG2];
      if (seg_next) cur_addr_q <= end_addr_q + 32'd1;
    end
  end

`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
      timeout_q  <= job_timeout;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.req_ready       = req_ready_q;
  assign bus.start_addr      = start_addr_q;
  assign bus.end_addr        = end_addr_q;
  assign bus.mode            = mode_out_q;
  assign bus.switch_die_need = switch_die_q;
  assign bus.start_flag      = start_flag_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_spi_flash_read_sched.sv
// Bench for spi_flash_read_sched: a range-splitting model predicts each segment and
// the cycle of every start_flag/done/err/timeout pulse; one process compares every cycle.
`timescale 1ns/1ps
module tb_spi_flash_read_sched;
  import spi_flash_pkg::*;

  localparam int DIE_LOG2 = 25;
  localparam int SEG_LOG2 = 12;
  localparam longint unsigned DIE_BYTES = 64'd1 << DIE_LOG2;
  localparam longint unsigned SEG_BYTES = 64'd1 << SEG_LOG2;
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e state_dbg;
  int     cyc = 0;

  spi_flash_read_sched_if bus();

  spi_flash_read_sched #(
    .DIE_SIZE_LOG2 (DIE_LOG2),
    .SEG_MAX_LOG2  (SEG_LOG2)
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_CYC)
`endif
  ) dut (
    .system_clk     (clk),
    .system_reset_n (rst_n),
    .bus            (bus),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model / scoreboard ----------------
  logic [66:0] exp_q[$];   // {switch_die, mode, start, end}
  longint unsigned model_die = 0;
  int  exp_sf_at = -1, exp_done_at = -1, exp_err_at = -1, exp_to_at = -1;
  bit  model_busy = 1'b0;
  bit  checking = 1'b0;
  int  n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic int build_segs(input logic [31:0] addr, input logic [31:0] len,
                                    input logic [1:0] md);
    longint unsigned cur, last, lenl, seg_lim, die_lim, e, die;
    logic [1:0] m;
    logic       sw;
    int         n;
    n    = 0;
    m    = (md == 2'b11) ? 2'b00 : md;
    cur  = addr;
    lenl = len;
    last = cur + lenl - 1;
    do begin
      seg_lim = (cur / SEG_BYTES + 1) * SEG_BYTES - 1;
      die_lim = (cur / DIE_BYTES + 1) * DIE_BYTES - 1;
      e = last;
      if (seg_lim < e) e = seg_lim;
      if (die_lim < e) e = die_lim;
      die = cur / DIE_BYTES;
      sw  = (die != model_die);
      exp_q.push_back({sw, m, cur[31:0], e[31:0]});
      model_die = die;
      n++;
      cur = e + 1;
    end while (cur <= last);
    return n;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      logic [66:0] f;
      chk("start_flag", 64'(bus.start_flag), 64'(cyc == exp_sf_at));
      if (bus.start_flag) begin
        chk("seg_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          chk("start_addr", 64'(bus.start_addr), 64'(f[63:32]));
          chk("end_addr", 64'(bus.end_addr), 64'(f[31:0]));
          chk("mode", 64'(bus.mode), 64'(f[65:64]));
          chk("switch_die_need", 64'(bus.switch_die_need), 64'(f[66]));
        end
      end
      chk("done", 64'(bus.done), 64'(cyc == exp_done_at));
      chk("err", 64'(bus.err), 64'(cyc == exp_err_at));
      chk("timeout", 64'(bus.timeout), 64'(cyc == exp_to_at));
      chk("busy", 64'(bus.busy), 64'(model_busy));
      chk("req_ready", 64'(bus.req_ready), 64'(!model_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start_flag"}, 64'(bus.start_flag), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_start_addr"}, 64'(bus.start_addr), 64'd0);
    chk({tag, "_end_addr"}, 64'(bus.end_addr), 64'd0);
    chk({tag, "_mode"}, 64'(bus.mode), 64'd0);
    chk({tag, "_switch_die"}, 64'(bus.switch_die_need), 64'd0);
    chk({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic mid_reset();
    #2;
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    model_die = 0;
    exp_sf_at = -1; exp_done_at = -1; exp_err_at = -1; exp_to_at = -1;
    model_busy = 1'b0;
    bus.read_finish = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checking = 1'b1;
  endtask

  task automatic run_job(input logic [31:0] addr, input logic [31:0] len,
                         input logic [1:0] md, input int abort_seg);
    longint unsigned sum;
    int nseg, c, f;
    sum = addr;
    sum = sum + len;
    c = cyc;
    bus.req_addr = addr; bus.req_len = len; bus.req_mode = md; bus.req_valid = 1'b1;
    if (len == 0 || sum > 64'h1_0000_0000) begin
      exp_err_at = c + 1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      return;
    end
    nseg = build_segs(addr, len, md);
    exp_sf_at = c + 2;
    tick();
    bus.req_valid = 1'b0;
    model_busy = 1'b1;
    for (int i = 0; i < nseg; i++) begin
      while (cyc < exp_sf_at) tick();
      if ($urandom_range(0, 3) == 0) bus.read_finish = 1'b1;
      tick();
      bus.read_finish = 1'b0;
      if (i == abort_seg) begin
        mid_reset();
        return;
      end
      repeat ($urandom_range(0, 4)) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.req_valid = 1'b1;
          bus.req_addr = $urandom();
          bus.req_len = $urandom();
        end
        tick();
        bus.req_valid = 1'b0;
      end
      f = cyc;
      bus.read_finish = 1'b1;
      if (i == nseg - 1) exp_done_at = f + 1;
      else exp_sf_at = f + 2;
      tick();
      if (i == nseg - 1) model_busy = 1'b0;
      bus.read_finish = ($urandom_range(0, 2) == 0);
      tick();
      bus.read_finish = 1'b0;
    end
  endtask

`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
  task automatic timeout_job();
    int c, n;
    c = cyc;
    bus.req_addr = 32'h100; bus.req_len = 32'd4; bus.req_mode = 2'b00; bus.req_valid = 1'b1;
    n = build_segs(32'h100, 32'd4, 2'b00);
    exp_sf_at = c + 2;
    tick();
    bus.req_valid = 1'b0;
    model_busy = 1'b1;
    while (cyc < exp_sf_at) tick();
    exp_to_at = exp_sf_at + 1 + int'(TO_CYC);
    while (cyc < exp_to_at) tick();
    model_busy = 1'b0;
    tick();
    chk("to_seg_count", 64'(n), 64'd1);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_mode = '0;
    bus.read_finish = 1'b0;

    // Pin the model against hand-computed splits.
    chk("pin_die_n", 64'(build_segs(32'h01FFFFFA, 32'h16, 2'b00)), 64'd2);
    chk("pin_die_s0", 64'(exp_q[0] == {1'b0, 2'b00, 32'h01FFFFFA, 32'h01FFFFFF}), 64'd1);
    chk("pin_die_s1", 64'(exp_q[1] == {1'b1, 2'b00, 32'h02000000, 32'h0200000F}), 64'd1);
    exp_q.delete(); model_die = 0;
    chk("pin_seg_n", 64'(build_segs(32'hFF0, 32'h20, 2'b10)), 64'd2);
    chk("pin_seg_s0", 64'(exp_q[0] == {1'b0, 2'b10, 32'h00000FF0, 32'h00000FFF}), 64'd1);
    chk("pin_seg_s1", 64'(exp_q[1] == {1'b0, 2'b10, 32'h00001000, 32'h0000100F}), 64'd1);
    exp_q.delete(); model_die = 0;

    repeat (2) tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(bus.req_ready), 64'd1);
    checking = 1'b1;

    repeat (4) begin
      bus.read_finish = $urandom_range(0, 1) == 1;
      tick();
    end
    bus.read_finish = 1'b0;

    run_job(32'h0, 32'd12, 2'b00, -1);
    chk("hold_end_0", 64'(bus.end_addr), 64'hB);
    chk("hold_start_0", 64'(bus.start_addr), 64'h0);
    run_job(32'h01FFFFFA, 32'h16, 2'b00, -1);
    chk("hold_end_1", 64'(bus.end_addr), 64'h0200000F);
    chk("hold_sw_1", 64'(bus.switch_die_need), 64'd1);
    run_job(32'h0, 32'd4, 2'b01, -1);
    chk("back_to_die0_sw", 64'(bus.switch_die_need), 64'd1);
    run_job(32'hFF0, 32'h20, 2'b10, -1);
    chk("hold_mode_quad", 64'(bus.mode), 64'd2);
    run_job(32'h1234, 32'd0, 2'b00, -1);
    run_job(32'hFFFFFFF0, 32'h20, 2'b00, -1);
    chk("hold_after_err", 64'(bus.end_addr), 64'h100F);
    run_job(32'hFFFFFFF0, 32'h10, 2'b11, -1);
    chk("top_end", 64'(bus.end_addr), 64'hFFFFFFFF);
    chk("mode11_as_00", 64'(bus.mode), 64'd0);
    run_job(32'h01FFFFFA, 32'h16, 2'b00, 1);
    run_job(32'h02000000, 32'd8, 2'b00, -1);
    chk("die_after_rst_sw", 64'(bus.switch_die_need), 64'd1);
`ifdef SPI_FLASH_SCHED_TIMEOUT_EN
    timeout_job();
    exp_q.delete();
`endif

    for (int j = 0; j < 40; j++) begin
      logic [31:0] a, l;
      int r;
      r = $urandom_range(0, 9);
      a = $urandom();
      if (r < 4) a = {a[31:25], 13'h1FFF, a[11:0]};
      else if (r < 7) a = {a[31:12], 4'hF, a[7:0]};
      if (r == 7) l = 32'd0;
      else if (r == 8) l = 32'hFFFFFFFF - a + 32'd1 + 32'($urandom_range(1, 16));
      else l = 32'($urandom_range(1, 9000));
      run_job(a, l, 2'($urandom_range(0, 3)), -1);
    end

    repeat (3) tick();
    chk("leftover_segs", 64'(exp_q.size()), 64'd0);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_sched.md
Name: spi_flash_read_sched

Overview:
Upstream request scheduler for spi_flash_read. Accepts one byte-range read job (address, length, mode) over a valid/ready handshake. Splits the job into segments that never cross a die boundary or a segment-size boundary. Drives start_addr/end_addr/mode/switch_die_need/start_flag into spi_flash_read one segment at a time, waiting for read_finish between segments.

Parameters:
DIE_SIZE_LOG2, 25, die size = 2^25 bytes (32 MiB); die index = addr[31:DIE_SIZE_LOG2]
SEG_MAX_LOG2, 12, maximum segment = 2^12 bytes, aligned; keeps rom_data_num within 16 bits
TIMEOUT_CYCLES, 1048576, WAIT-state watchdog limit (used only with SPI_FLASH_SCHED_TIMEOUT_EN)

Ports:
system_clk  in  1  system clock
system_reset_n  in  1  asynchronous active-low reset
req_valid  in  1  job request valid
req_ready  out  1  high in IDLE only
req_addr  in  32  first byte address
req_len  in  32  byte count (must be >0)
req_mode  in  2  00 single, 01 dual, 10 quad; 11 treated as 00
start_addr  out  32  segment first address
end_addr  out  32  segment last address (inclusive)
mode  out  2  segment read mode
switch_die_need  out  1  segment requires die-select before read
start_flag  out  1  one-cycle segment launch pulse
read_finish  in  1  segment complete, from spi_flash_read
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last segment's read_finish
err  out  1  one-cycle pulse on rejected job
timeout  out  1  one-cycle pulse on watchdog abort (tied 0 without macro)

Behaviour:
- Clock and reset: one clock, system_clk. Reset is asynchronous, active-low, on system_reset_n.
- Reset values: all outputs 0; req_ready is 0 during reset and 1 from the first clock after release. Internal cur_die is reset to 0.
- FSM states: IDLE, CALC, ISSUE, WAIT.
- IDLE:
  - Handshake completes when req_valid && req_ready. On that edge, latch req_addr, last = req_addr+req_len-1 (33-bit calc) and mode.
  - Reject when req_len==0 or bit 32 of the sum is set: pulse err the next cycle and stay in IDLE.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - seg_end = min(last, cur_addr | (2^SEG_MAX_LOG2-1), cur_addr | (2^DIE_SIZE_LOG2-1)).
  - switch_die_need = (cur_addr die index != cur_die).
  - Register start_addr = cur_addr and end_addr = seg_end.
- ISSUE (1 cycle):
  - start_flag=1. Update cur_die to the segment's die index.
  - Go to WAIT.
- WAIT:
  - read_finish is sampled only from the cycle after start_flag. A read_finish coincident with start_flag is ignored.
  - On read_finish: if end_addr==last, pulse done and go to IDLE. Otherwise set cur_addr = end_addr+1 and go to CALC.
- Output stability:
  - start_addr, end_addr, mode and switch_die_need hold from ISSUE until the next CALC.
  - In IDLE they keep the last segment's values.
- Latency: handshake edge → start_flag is 2 cycles (CALC, ISSUE). read_finish → next start_flag is 2 cycles.
- Stray inputs: read_finish in IDLE, CALC or ISSUE is ignored. req_valid while busy is ignored (req_ready=0).
- Address wrap: last=0xFFFFFFFF is legal, and no wrap past it is possible.
- Reset mid-job: the job is abandoned, all outputs are forced to reset values, and the next segment restarts with cur_die=0.

Optional Feature:
SPI_FLASH_SCHED_TIMEOUT_EN:
- Defined: a counter runs in WAIT and clears on entering WAIT. On reaching TIMEOUT_CYCLES-1 without read_finish, pulse timeout, abandon the job (no done) and return to IDLE.
- Undefined: no counter; WAIT is unbounded; timeout is tied 0.

Decomposition:
- Shared package spi_flash_pkg: FSM state encoding, mode codes (MODE_SINGLE/DUAL/QUAD), DIE_SIZE_LOG2 default, and a segment record {start, end, switch_die}.
- One natural sub-module: spi_flash_seg_calc, a combinational seg_end/switch_die computation instantiated by CALC.

Test Plan:
- addr 0x00000000, len 12, mode 00 → one start_flag, start_addr 0x0, end_addr 0xB, switch_die_need 0; done 1 cycle after read_finish.
- addr 0x01FFFFFA, len 0x16 → segment 0x01FFFFFA–0x01FFFFFF with switch_die_need 0, then segment 0x02000000–0x0200000F with switch_die_need 1; a second job at 0x0 gives switch_die_need 1.
- addr 0x00000FF0, len 0x20, mode 10 → segments 0xFF0–0xFFF and 0x1000–0x100F, mode 10 on both, one done.
- len 0, then addr 0xFFFFFFF0 len 0x20 → err pulse each time, no start_flag, req_ready high the next cycle.
- Reset asserted in WAIT of segment 2 → all outputs 0 immediately; the next job at 0x02000000 gives switch_die_need 1.
- With macro defined and TIMEOUT_CYCLES=16, read_finish withheld → timeout pulse 16 cycles into WAIT, no done, req_ready high.
